pipe_stage_buf: RTL and testbench
=================================

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 64, giving the payload width (e.g. PC+4 concatenated with the instruction).
REQ-002 SHALL have parameter SKID, default 1, selecting the 2-entry skid mode (1) or the 1-entry pass-through-ready mode (0).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port flush, input, 1: discards all held entries and any same-cycle input.
REQ-006 SHALL have port in_valid, input, 1: upstream payload valid.
REQ-007 SHALL have port in_ready, output, 1: stage accepts the payload this cycle.
REQ-008 SHALL have port in_data, input, WIDTH: upstream payload.
REQ-009 SHALL have port out_valid, output, 1: out_data holds a valid entry.
REQ-010 SHALL have port out_ready, input, 1: downstream consumes the entry this cycle.
REQ-011 SHALL have port out_data, output, WIDTH: head entry.
REQ-012 SHALL have port occupancy, output, 2: number of held entries (0..2).

Function
REQ-013 SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready; data moves only on fire.
REQ-014 SHALL, with SKID=1, implement states EMPTY(0), HALF(1), FULL(2) with a head register and a skid register.
REQ-015 SHALL, with SKID=1, drive in_ready = (state != FULL) from state only, with no combinational path from out_ready.
REQ-016 SHALL drive out_valid = (state != EMPTY) and out_data = head register.
REQ-017 SHALL, in EMPTY, move to HALF with head <= in_data on in_fire, and otherwise stay in EMPTY.
REQ-018 SHALL, in HALF, make the following transitions:
- in_fire & out_fire: stay in HALF, head <= in_data.
- in_fire only: go to FULL, skid <= in_data.
- out_fire only: go to EMPTY.
- neither: hold.
REQ-019 SHALL, in FULL, on out_fire go to HALF with head <= skid, and otherwise hold.
REQ-020 SHALL, with SKID=0, use EMPTY/HALF only and drive in_ready = ~out_valid | out_ready (combinational), giving single-entry throughput of 1 per cycle.
REQ-021 SHALL have a latency of 1 cycle from in_fire to out_valid in EMPTY, and sustain 1 transfer per cycle while out_ready=1.
REQ-022 SHALL preserve entry order; no entry is duplicated or lost except by flush.
REQ-023 SHALL, on flush=1 at an edge, go to EMPTY and clear head and skid to 0 regardless of fires.
REQ-024 SHALL treat an in_fire coincident with flush as accepted and dropped.
REQ-025 SHALL report an out_fire coincident with flush as consumed by downstream.
REQ-026 SHALL hold out_data = 0 whenever out_valid=0 after reset or flush; data registers never hold X.
REQ-027 SHALL drive occupancy = state encoding (0, 1, 2), registered.

Reset
REQ-028 SHALL, on rst_n=0, immediately (asynchronously) force state=EMPTY, head=0, skid=0, out_valid=0 and occupancy=0.
REQ-029 SHALL drive in_ready=1 during reset.
REQ-030 SHALL resume normal operation on the first rising edge after rst_n deasserts.
REQ-031 SHALL lose all held entries on reset asserted mid-transfer, with no spurious out_valid after release.

Structure
REQ-032 SHALL place the state enum typedef (EMPTY/HALF/FULL) and the occupancy width constant in the shared pipeline package.
REQ-033 SHALL be a single module with no sub-module; WIDTH and SKID are resolved by generate.

Verification
REQ-034 SHALL cover streaming: SKID=1, out_ready=1, in_valid=1 with in_data 1,2,3,4 -> out_data 1,2,3,4 on consecutive cycles, one cycle later, in_ready constant 1.
REQ-035 SHALL cover backpressure: SKID=1, out_ready=0, push A then B -> occupancy 2, in_ready=0, out_data=A; raise out_ready -> A then B drained, occupancy 2->1->0.
REQ-036 SHALL cover flush: flush while FULL with in_valid=1 (data C) -> next cycle out_valid=0, out_data=0, occupancy=0, C never appears.
REQ-037 SHALL cover SKID=0: out_ready=0 with head valid -> in_ready=0 the same cycle; out_ready=1 -> in_ready=1 combinationally and the new entry replaces head.
REQ-038 SHALL cover mid-operation reset: rst_n low mid-cycle while FULL -> outputs cleared before the next edge; after release, push D -> out_data=D after 1 cycle.
REQ-039 SHALL check invariants every cycle: order preservation, no X on out_data, and in_ready=0 only in FULL (SKID=1).

Source files
------------

// File: rtl/pipe_stage_buf_pkg.sv
// Shared pipeline definitions: buffer state encoding and occupancy width.
// The state encoding doubles as the occupancy count.
package pipe_stage_buf_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [OCC_W-1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline stage buffer: 2-entry skid buffer (SKID=1) or
// 1-entry buffer with pass-through ready (SKID=0).
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter bit SKID  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  stage_state_e     state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire, out_fire;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = head_q;
  assign occupancy = state_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Skid mode breaks the ready path; pass-through mode trades that for one register.
  generate
    if (SKID) begin : g_skid_ready
      assign in_ready = (state_q != FULL);
    end else begin : g_pass_ready
      assign in_ready = ~out_valid | out_ready;
    end
  endgenerate

  // Vacated registers are zeroed so out_data reads 0 whenever nothing is held.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = HALF;
          head_d  = in_data;
        end
      end
      HALF: begin
        if (in_fire && out_fire) begin
          head_d = in_data;
        end else if (in_fire && SKID) begin
          state_d = FULL;
          skid_d  = in_data;
        end else if (out_fire) begin
          state_d = EMPTY;
          head_d  = '0;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d = HALF;
          head_d  = skid_q;
          skid_d  = '0;
        end
      end
      default: begin
        state_d = EMPTY;
        head_d  = '0;
        skid_d  = '0;
      end
    endcase
    if (flush) begin
      state_d = EMPTY;
      head_d  = '0;
      skid_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: skid and pass-through instances share stimulus and
// are compared each cycle against bounded-queue models.
module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [63:0] in_data;
  logic        out_ready;

  logic        s_in_ready, s_out_valid;
  logic [63:0] s_out_data;
  logic [1:0]  s_occupancy;
  logic        p_in_ready, p_out_valid;
  logic [63:0] p_out_data;
  logic [1:0]  p_occupancy;

  int checks = 0;
  int errors = 0;

  logic [63:0] skid_q[$];
  logic [63:0] pass_q[$];

  always #5 clk = ~clk;

  pipe_stage_buf #(.WIDTH(64), .SKID(1'b1)) u_skid (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .occupancy(s_occupancy)
  );

  pipe_stage_buf #(.WIDTH(64), .SKID(1'b0)) u_pass (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(p_in_ready), .in_data(in_data),
    .out_valid(p_out_valid), .out_ready(out_ready), .out_data(p_out_data),
    .occupancy(p_occupancy)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Expected outputs follow from the queue contents and the current out_ready.
  task automatic checkModels();
    checkOutput("skid_in_ready", 64'(s_in_ready), 64'(skid_q.size() < 2));
    checkOutput("skid_out_valid", 64'(s_out_valid), 64'(skid_q.size() > 0));
    checkOutput("skid_out_data", s_out_data, (skid_q.size() > 0) ? skid_q[0] : 64'd0);
    checkOutput("skid_occupancy", 64'(s_occupancy), 64'(skid_q.size()));
    checkOutput("pass_in_ready", 64'(p_in_ready), 64'(pass_q.size() == 0 || out_ready));
    checkOutput("pass_out_valid", 64'(p_out_valid), 64'(pass_q.size() > 0));
    checkOutput("pass_out_data", p_out_data, (pass_q.size() > 0) ? pass_q[0] : 64'd0);
    checkOutput("pass_occupancy", 64'(p_occupancy), 64'(pass_q.size()));
  endtask

  // Entered and left just after a rising edge; one call is one clock cycle.
  task automatic applyStimulus(input logic fl, input logic iv, input logic [63:0] id,
                               input logic orr);
    bit s_in, s_out, p_in, p_out;
    flush     = fl;
    in_valid  = iv;
    in_data   = id;
    out_ready = orr;
    @(negedge clk);
    checkModels();
    s_in  = iv && (skid_q.size() < 2);
    s_out = orr && (skid_q.size() > 0);
    p_in  = iv && (pass_q.size() == 0 || orr);
    p_out = orr && (pass_q.size() > 0);
    if (fl) begin
      skid_q.delete();
      pass_q.delete();
    end else begin
      if (s_out) void'(skid_q.pop_front());
      if (s_in) skid_q.push_back(id);
      if (p_out) void'(pass_q.pop_front());
      if (p_in) pass_q.push_back(id);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] a, b, c, d;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #2;
    checkOutput("rst_skid_in_ready", 64'(s_in_ready), 64'd1);
    checkOutput("rst_pass_in_ready", 64'(p_in_ready), 64'd1);
    checkOutput("rst_out_valid", 64'(s_out_valid), 64'd0);
    checkOutput("rst_out_data", s_out_data, 64'd0);
    checkOutput("rst_occupancy", 64'(s_occupancy), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b0, 1'b1, 64'(i), 1'b1);
      checkOutput("stream_data", s_out_data, 64'(i));
      checkOutput("stream_in_ready", 64'(s_in_ready), 64'd1);
    end
    applyStimulus(1'b0, 1'b0, 64'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 64'd0, 1'b1);

    a = 64'hAAAA_0000_0000_000A;
    b = 64'hBBBB_0000_0000_000B;
    applyStimulus(1'b0, 1'b1, a, 1'b0);
    applyStimulus(1'b0, 1'b1, b, 1'b0);
    checkOutput("bp_occupancy", 64'(s_occupancy), 64'd2);
    checkOutput("bp_in_ready", 64'(s_in_ready), 64'd0);
    checkOutput("bp_head", s_out_data, a);
    checkOutput("pass_stall_ready", 64'(p_in_ready), 64'd0);
    out_ready = 1'b1;
    #1;
    checkOutput("pass_release_ready", 64'(p_in_ready), 64'd1);
    applyStimulus(1'b0, 1'b0, 64'd0, 1'b1);
    checkOutput("drain1_occupancy", 64'(s_occupancy), 64'd1);
    checkOutput("drain1_head", s_out_data, b);
    applyStimulus(1'b0, 1'b0, 64'd0, 1'b1);
    checkOutput("drain2_occupancy", 64'(s_occupancy), 64'd0);

    applyStimulus(1'b0, 1'b1, 64'h11, 1'b0);
    applyStimulus(1'b0, 1'b1, 64'h22, 1'b1);
    checkOutput("pass_replace_head", p_out_data, 64'h22);

    c = 64'hCCCC_CCCC_CCCC_CCCC;
    applyStimulus(1'b0, 1'b1, 64'h33, 1'b0);
    applyStimulus(1'b1, 1'b1, c, 1'b0);
    checkOutput("flush_out_valid", 64'(s_out_valid), 64'd0);
    checkOutput("flush_out_data", s_out_data, 64'd0);
    checkOutput("flush_occupancy", 64'(s_occupancy), 64'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 64'd0, 1'b1);

    applyStimulus(1'b0, 1'b1, 64'h44, 1'b0);
    applyStimulus(1'b0, 1'b1, 64'h55, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mrst_out_valid", 64'(s_out_valid), 64'd0);
    checkOutput("mrst_out_data", s_out_data, 64'd0);
    checkOutput("mrst_occupancy", 64'(s_occupancy), 64'd0);
    checkOutput("mrst_in_ready", 64'(s_in_ready), 64'd1);
    skid_q.delete();
    pass_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    d = 64'hDDDD_0000_DDDD_0000;
    applyStimulus(1'b0, 1'b0, 64'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, d, 1'b0);
    checkOutput("mrst_push_data", s_out_data, d);
    checkOutput("mrst_push_valid", 64'(s_out_valid), 64'd1);

    for (int i = 0; i < 2000; i++) begin
      applyStimulus(($urandom_range(15) == 0), 1'($urandom), {$urandom, $urandom},
                    ($urandom_range(3) != 0) ? 1'($urandom) : 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
